// File: rtl/mult_sequencer.sv
// mult_sequencer: radix-2 shift-add multiplier with hi/lo product registers and a pipeline stall flag.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_e,
  input  logic             signed_e,
  input  logic [WIDTH-1:0] srca_e,
  input  logic [WIDTH-1:0] srcb_e,
  input  logic             mthi_e,
  input  logic             mtlo_e,
  output logic             mult_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step;
  logic [WIDTH:0]     sum;
  logic               neg_q, neg_d, busy_q, a_neg, b_neg, mv_ok;
  always_comb begin
    a_neg    = signed_e & srca_e[WIDTH-1];
    b_neg    = signed_e & srcb_e[WIDTH-1];
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{mplier_q[0]}}};
    step     = {sum, acc_q[WIDTH-1:1]};
    mv_ok    = (state_q == DONE) | (state_q == IDLE & ~start_e);
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = mv_ok & mthi_e ? srca_e : hi_q;
    lo_d     = mv_ok & mtlo_e ? srca_e : lo_q;
    case (state_q)
      IDLE: if (start_e) begin
        mcand_d  = a_neg ? -srca_e : srca_e;
        mplier_d = b_neg ? -srcb_e : srcb_e;
        neg_d    = a_neg ^ b_neg;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH);
        state_d  = RUN;
      end
      RUN: begin
        acc_d    = step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d      = DONE;
          {hi_d, lo_d} = neg_q ? -step : step;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= state_d == RUN;
    end
  end
  assign mult_done = ~(state_q == RUN | (state_q == IDLE & start_e));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed table, corner sequences and random multiplies against an arithmetic model.
module tb_mult_sequencer;
  logic        clk = 0, reset_n = 0, start_e = 0, signed_e = 0, mthi_e = 0, mtlo_e = 0;
  logic [31:0] srca_e = 0, srcb_e = 0, hi, lo;
  logic        mult_done, busy;
  int          n_vec = 0, n_bad = 0;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start_e(start_e), .signed_e(signed_e),
    .srca_e(srca_e), .srcb_e(srcb_e), .mthi_e(mthi_e), .mtlo_e(mtlo_e),
    .mult_done(mult_done), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [31:0] a, b, eh, el;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (!s) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Called half a cycle before a negedge; returns sampling inside the DONE cycle with start_e still high.
  task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input bit mv_start, input bit mv_mid);
    logic [31:0] h0, l0;
    int stall, busy_n;
    bit moved;
    h0 = hi; l0 = lo; stall = 0; busy_n = 0; moved = 0;
    start_e = 1; signed_e = s; srca_e = a; srcb_e = b; mthi_e = mv_start;
    repeat (100) begin
      @(negedge clk); #1;
      if (mult_done) break;
      stall++;
      busy_n += int'(busy);
      if (hi !== h0 || lo !== l0) moved = 1;
      if (stall == 2) mthi_e = 0;
      mtlo_e = mv_mid && stall == 5;
      if (mv_mid && stall == 5) srca_e = 32'h1234_5678;
    end
    mthi_e = 0; mtlo_e = 0;
    chk("stall_len", 64'(stall), 64'd33);
    chk("busy_cycles", 64'(busy_n), 64'd32);
    chk("hilo_hold", 64'(moved), 64'd0);
    chk("busy_done", 64'(busy), 64'd0);
    chk("product", {hi, lo}, {eh, el});
  endtask

  task automatic release_start();
    @(posedge clk); #1;
    start_e = 0;
    @(negedge clk); #1;
    chk("no_retrig", {62'b0, mult_done, busy}, 64'b10);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] edge_v[5];
    logic [31:0] ra, rb;
    bit rs;
    tbl[0] = '{0, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};
    tbl[1] = '{1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[3] = '{1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[4] = '{0, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA};
    tbl[5] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    tbl[6] = '{1, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000};
    tbl[7] = '{1, 32'd0,         32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0000};
    edge_v = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

    #12;
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_flags", {62'b0, mult_done, busy}, 64'b10);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("post_reset_idle", {62'b0, mult_done, busy}, 64'b10);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, 0, 0);
      release_start();
    end

    mthi_e = 1; srca_e = 32'hAAAA_5555;
    @(posedge clk); #1;
    mthi_e = 0;
    chk("mthi_idle", 64'(hi), 64'hAAAA_5555);
    mtlo_e = 1; srca_e = 32'h5555_AAAA;
    @(posedge clk); #1;
    mtlo_e = 0;
    chk("mtlo_idle", 64'(lo), 64'h5555_AAAA);

    run(0, 32'd7, 32'd9, 32'h0, 32'h3F, 1, 0);
    release_start();
    run(0, 32'd3, 32'd5, 32'h0, 32'hF, 0, 1);
    @(posedge clk); #1;
    run(1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0);
    release_start();

    start_e = 1; signed_e = 0; srca_e = 32'd7; srcb_e = 32'd9;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 0; start_e = 0;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_flags", {62'b0, mult_done, busy}, 64'b10);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    chk("abort_idle", {62'b0, mult_done, busy}, 64'b10);
    run(0, 32'd7, 32'd9, 32'h0, 32'h3F, 0, 0);
    release_start();

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom_range(0, 3) == 0 ? edge_v[$urandom_range(0, 4)] : $urandom;
      rb = $urandom_range(0, 3) == 0 ? edge_v[$urandom_range(0, 4)] : $urandom;
      p = ref_prod(rs, ra, rb);
      run(rs, ra, rb, p[63:32], p[31:0], 0, 0);
      release_start();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; WIDTH SHALL be at least 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start_e  input  1  multiply instruction present in Execute stage, held high while the pipeline stalls.
REQ-005 Port: signed_e  input  1  1 = signed (two's complement) multiply, 0 = unsigned.
REQ-006 Port: srca_e  input  WIDTH  multiplicand.
REQ-007 Port: srcb_e  input  WIDTH  multiplier.
REQ-008 Port: mthi_e / mtlo_e  input  1 each  write srca_e directly into hi / lo.
REQ-009 Port: mult_done  output  1  0 = multiplier busy, pipeline stalls (feeds hazard unit multstall = ~mult_done).
REQ-010 Port: hi  output  WIDTH  upper half of product register.
REQ-011 Port: lo  output  WIDTH  lower half of product register.
REQ-012 Port: busy  output  1  registered, 1 while in RUN.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE with start_e=1: the block SHALL latch operand magnitudes, signed_e, and the result sign (sign(a) XOR sign(b) if signed_e, else 0), clear the accumulator, load the iteration counter with WIDTH, and go to RUN.
REQ-015 RUN: each cycle one radix-2 shift-add step SHALL be performed (add multiplicand to the upper accumulator half if the multiplier LSB is 1, then shift the 2*WIDTH accumulator right one bit); counter decrements; after exactly WIDTH RUN cycles the state SHALL go to DONE.
REQ-016 The DONE transition edge SHALL write the 2*WIDTH product into {hi, lo}, negated (two's complement over 2*WIDTH bits) when the latched result sign is 1.
REQ-017 DONE SHALL last exactly one cycle and return to IDLE unconditionally; start_e in DONE SHALL be ignored (prevents retrigger by the held instruction).
REQ-018 start_e in RUN SHALL be ignored.
REQ-019 mult_done SHALL be combinational: 0 when state==RUN, or state==IDLE and start_e==1; 1 otherwise.
REQ-020 Stall length per multiply SHALL therefore be WIDTH+1 cycles (accept cycle + WIDTH RUN cycles); mult_done SHALL be 1 in DONE, with hi/lo already updated.
REQ-021 Signed magnitude: the most negative operand (1 followed by WIDTH-1 zeros) SHALL use magnitude 2^(WIDTH-1), held in an unsigned WIDTH-bit register without overflow.
REQ-022 mthi_e / mtlo_e SHALL write hi / lo on the clock edge only in IDLE or DONE; in RUN they SHALL be ignored.
REQ-023 IDLE with start_e and mthi_e/mtlo_e both high: start_e SHALL win; the move SHALL be dropped.
REQ-024 hi and lo SHALL change only on the DONE transition or an accepted mthi_e/mtlo_e.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, counter=0, accumulator=0, hi=0, lo=0, busy=0.
REQ-026 With reset_n low and start_e=0, mult_done SHALL be 1.
REQ-027 reset_n asserted mid-RUN SHALL abort the operation; no partial result SHALL reach hi/lo.
REQ-028 The first edge after reset_n release SHALL behave as IDLE.

Verification
REQ-029 Unsigned 3 x 5, WIDTH=32: start_e held -> mult_done low exactly 33 cycles; in DONE hi=0x00000000, lo=0x0000000F.
REQ-030 Signed -2 x 3 (0xFFFFFFFE, 0x00000003) -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-032 reset_n pulsed low in RUN cycle 10 of a 7 x 9 multiply -> immediate IDLE, hi=lo=0, mult_done=1, busy=0; a later 7 x 9 gives lo=0x3F.
REQ-033 start_e held high through DONE, dropped one cycle later -> exactly one multiply; a second start_e in the cycle after DONE -> new 33-cycle stall with correct second product.
REQ-034 mthi_e with srca_e=0xAAAA5555 in IDLE -> hi=0xAAAA5555 next cycle; mtlo_e during RUN -> lo unchanged until DONE writes the product.
